// File: rtl/timer_pkg.sv
// Shared types and default sizes for the down_timer block.
package timer_pkg;

  localparam int unsigned CNT_W_DEF      = 4;
  localparam int unsigned PRESCALE_W_DEF = 26;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a timer client (master) and down_timer (slave).
interface down_timer_if #(
  parameter int unsigned CNT_W = timer_pkg::CNT_W_DEF
);

  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             enable;
  logic [CNT_W-1:0] counter_out;
  logic             running;
  logic             done;

  modport master (
    output load, load_value, enable,
    input  counter_out, running, done
  );

  modport slave (
    input  load, load_value, enable,
    output counter_out, running, done
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: tick marks the advancing edge on which it wraps to zero.
module tick_gen
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic tick
);

  logic [PRESCALE_W-1:0] presc_q;

  // clear outranks advance so a restart always begins a full period
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      presc_q <= '0;
    end else if (advance) begin
      presc_q <= presc_q + PRESCALE_W'(1);
    end
  end

  assign tick = advance && (&presc_q);

endmodule

// File: rtl/down_timer.sv
// Loadable countdown timer with pause/resume and a one-cycle expiry pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  down_timer_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             running_q;
  logic             done_q, done_d;
  logic             advance;
  logic             tick;

  // A paused timer counts the edge on which it resumes, so a pause of N cycles
  // delays expiry by exactly N cycles.
  assign advance = bus.enable && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.load),
    .advance(advance),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= done_d;
    end
  end

  // Next state and count; load overrides any tick in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (bus.load) begin
      count_d = bus.load_value;
      if (bus.load_value == '0) begin
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = bus.enable ? ST_RUN : ST_PAUSE;
      end
    end else begin
      unique case (state_q)
        ST_RUN, ST_PAUSE: begin
          if (!bus.enable) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
            if (tick && (count_q != '0)) begin
              count_d = count_q - CNT_W'(1);
              if (count_q == CNT_W'(1)) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_IDLE:    state_d = ST_IDLE;
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.counter_out = count_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer with a 4-cycle tick (PRESCALE_W=2).
module tb_down_timer;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned PRESCALE_W = 2;

  typedef struct {
    logic             rst;
    logic             ld;
    logic [CNT_W-1:0] lv;
    logic             en;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             dn;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  down_timer_if #(.CNT_W(CNT_W)) bus ();

  down_timer #(
    .CNT_W     (CNT_W),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic add(input logic rst, input logic ld, input logic [CNT_W-1:0] lv,
                     input logic en, input logic [CNT_W-1:0] cnt,
                     input logic run, input logic dn);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = lv; v.en = en;
    v.cnt = cnt; v.run = run; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d exp=%0d", name, idx, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic ld, input logic [CNT_W-1:0] lv,
                      input logic en);
    reset          = rst;
    bus.load       = ld;
    bus.load_value = lv;
    bus.enable     = en;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input int idx, input int cnt,
                            input int run, input int dn);
    chk({name, ".count"},   idx, int'(bus.counter_out), cnt);
    chk({name, ".running"}, idx, int'(bus.running), run);
    chk({name, ".done"},    idx, int'(bus.done), dn);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    bus.load = 1'b0;
    bus.load_value = '0;
    bus.enable = 1'b0;

    // reset, enable alone in IDLE, then load 3 and run to expiry
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 3, 1, 3, 1, 0);
    for (int k = 1; k <= 15; k++)
      add(0, 0, 0, 1, CNT_W'(3 - k / 4), (k < 12) ? 1'b1 : 1'b0, (k == 12) ? 1'b1 : 1'b0);
    // load 1 with enable low lands in PAUSE, then resumes
    add(0, 1, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en);
      expect_out("vec", i, int'(vecs[i].cnt), int'(vecs[i].run), int'(vecs[i].dn));
    end

    // load 2, enable low on edges 2..6: tick at 9, expiry at 13
    step(1, 0, 0, 0);
    step(0, 1, 2, 1);
    expect_out("pause.load", 0, 2, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      logic en_k;
      en_k = (k >= 2 && k <= 6) ? 1'b0 : 1'b1;
      step(0, 0, 0, en_k);
      expect_out("pause", k, (k < 9) ? 2 : (k < 13) ? 1 : 0,
                 (k == 1 || (k >= 7 && k <= 12)) ? 1 : 0, (k == 13) ? 1 : 0);
    end

    // load 0: immediate expiry, single pulse, then silence
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    expect_out("zero.load", 0, 0, 0, 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 1);
      if (bus.done) pulses++;
    end
    chk("zero.extra_pulses", 0, pulses, 0);
    expect_out("zero.hold", 0, 0, 0, 0);

    // load 9 on the edge that would tick 5 -> 4
    step(1, 0, 0, 0);
    step(0, 1, 6, 1);
    for (int k = 1; k <= 7; k++) step(0, 0, 0, 1);
    expect_out("reload.pre", 0, 5, 1, 0);
    step(0, 1, 9, 1);
    expect_out("reload.edge", 0, 9, 1, 0);
    pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 1);
      if (bus.done) pulses++;
      expect_out("reload.hold", k, 9, 1, 0);
    end
    step(0, 0, 0, 1);
    expect_out("reload.tick", 0, 8, 1, 0);
    chk("reload.pulses", 0, pulses, 0);

    // reset with load mid-run abandons the count
    step(1, 0, 0, 0);
    step(0, 1, 5, 1);
    for (int k = 1; k <= 6; k++) step(0, 0, 0, 1);
    expect_out("rst.pre", 0, 4, 1, 0);
    step(1, 1, 7, 1);
    expect_out("rst.edge", 0, 0, 0, 0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 1);
      if (bus.done || bus.running || bus.counter_out != '0) pulses++;
    end
    chk("rst.idle_activity", 0, pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
